hilo_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers, downstream of the register file.

---
 rtl/mips_pkg.sv | 19 +
 rtl/hilo_muldiv_unit_if.sv | 27 ++
 rtl/muldiv_sign_fix.sv | 63 ++++++
 rtl/hilo_muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the HI/LO multiply/divide unit: operand width,
// MD op encodings and the controller state type.
package mips_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the pipeline controller and the HI/LO
// multiply/divide unit.
interface hilo_muldiv_unit_if;
  import mips_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] hi_out;
  logic [XLEN-1:0] lo_out;
  logic            busy;
  logic            done;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we,
    input  hi_out, lo_out, busy, done
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we,
    output hi_out, lo_out, busy, done
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Sign handling around the unsigned iterative core: operand magnitudes on the
// way in, conditional negation of product/quotient/remainder on the way out.
module muldiv_sign_fix
  import mips_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   rsData,
  input  logic [XLEN-1:0]   rtData,
  output logic [XLEN-1:0]   rsMag,
  output logic [XLEN-1:0]   rtMag,
  output logic              rsNeg,
  output logic              rtNeg,
  input  logic [1:0]        fixOp,
  input  logic              fixRsNeg,
  input  logic              fixRtNeg,
  input  logic              fixDivZero,
  input  logic [2*XLEN-1:0] product,
  input  logic [XLEN-1:0]   quotient,
  input  logic [XLEN-1:0]   remainder,
  output logic [XLEN-1:0]   hiFix,
  output logic [XLEN-1:0]   loFix
);

  logic              isSigned;
  logic [2*XLEN-1:0] prodFix;

  // Operand magnitudes; |0x80000000| stays 0x80000000 read as unsigned.
  always_comb begin
    isSigned = (op == MD_OP_MULT) || (op == MD_OP_DIV);
    rsNeg    = isSigned & rsData[XLEN-1];
    rtNeg    = isSigned & rtData[XLEN-1];
    rsMag    = rsNeg ? -rsData : rsData;
    rtMag    = rtNeg ? -rtData : rtData;
  end

  // Final result selection; sign flags are already zero for unsigned ops.
  always_comb begin
    prodFix = (fixRsNeg ^ fixRtNeg) ? -product : product;
    hiFix   = {XLEN{1'b0}};
    loFix   = {XLEN{1'b0}};
    case (fixOp)
      MD_OP_MULT, MD_OP_MULTU: begin
        hiFix = prodFix[2*XLEN-1:XLEN];
        loFix = prodFix[XLEN-1:0];
      end
      MD_OP_DIV, MD_OP_DIVU: begin
        // With a zero divisor the remainder is |rs|, so re-applying rs's
        // sign hands back the dividend exactly as it was latched.
        hiFix = fixRsNeg ? -remainder : remainder;
        if (fixDivZero) begin
          loFix = {XLEN{1'b1}};
        end else begin
          loFix = (fixRsNeg ^ fixRtNeg) ? -quotient : quotient;
        end
      end
      default: begin
        hiFix = {XLEN{1'b0}};
        loFix = {XLEN{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers;
// one result bit per clock, busy stalls the PC until done.
module hilo_muldiv_unit
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  hilo_muldiv_unit_if.slave  bus
);

  md_state_t         state;
  md_state_t         stateNext;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        opReg;
  logic              rsNegReg;
  logic              rtNegReg;
  logic              divZeroReg;
  logic [XLEN-1:0]   operandReg;
  logic [2*XLEN-1:0] accReg;
  logic [XLEN-1:0]   remReg;
  logic [XLEN-1:0]   hiReg;
  logic [XLEN-1:0]   loReg;
  logic              busyReg;
  logic              doneReg;

  logic [XLEN-1:0]   rsMag;
  logic [XLEN-1:0]   rtMag;
  logic              rsNeg;
  logic              rtNeg;
  logic [XLEN-1:0]   hiFix;
  logic [XLEN-1:0]   loFix;
  logic              isDiv;
  logic [XLEN:0]     mulSum;
  logic [XLEN:0]     divShift;
  logic [XLEN:0]     divDiff;

  muldiv_sign_fix signFix (
    .op         (bus.op),
    .rsData     (bus.rs_data),
    .rtData     (bus.rt_data),
    .rsMag      (rsMag),
    .rtMag      (rtMag),
    .rsNeg      (rsNeg),
    .rtNeg      (rtNeg),
    .fixOp      (opReg),
    .fixRsNeg   (rsNegReg),
    .fixRtNeg   (rtNegReg),
    .fixDivZero (divZeroReg),
    .product    (accReg),
    .quotient   (accReg[XLEN-1:0]),
    .remainder  (remReg),
    .hiFix      (hiFix),
    .loFix      (loFix)
  );

  // Shift-add keeps the multiplier in the low half of the accumulator; the
  // divider reuses that low half as the dividend/quotient shift register.
  // The 33-bit trial difference cannot overflow because the shifted
  // remainder is always below twice the divisor.
  assign isDiv    = (opReg == MD_OP_DIV) || (opReg == MD_OP_DIVU);
  assign mulSum   = {1'b0, accReg[2*XLEN-1:XLEN]}
                  + (accReg[0] ? {1'b0, operandReg} : {(XLEN+1){1'b0}});
  assign divShift = {remReg, accReg[XLEN-1]};
  assign divDiff  = divShift - {1'b0, operandReg};

  // Next-state logic for IDLE -> RUN -> FIX -> IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          stateNext = RUN;
        end else begin
          stateNext = IDLE;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(XLEN - 1)) begin
          stateNext = FIX;
        end else begin
          stateNext = RUN;
        end
      end
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register, iteration datapath and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= {CNT_W{1'b0}};
      opReg      <= 2'b00;
      rsNegReg   <= 1'b0;
      rtNegReg   <= 1'b0;
      divZeroReg <= 1'b0;
      operandReg <= {XLEN{1'b0}};
      accReg     <= {(2*XLEN){1'b0}};
      remReg     <= {XLEN{1'b0}};
      hiReg      <= {XLEN{1'b0}};
      loReg      <= {XLEN{1'b0}};
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
    end else begin
      state   <= stateNext;
      busyReg <= (stateNext != IDLE);
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hiReg <= bus.rs_data;
          if (bus.lo_we) loReg <= bus.rs_data;
          if (bus.start) begin
            opReg      <= bus.op;
            rsNegReg   <= rsNeg;
            rtNegReg   <= rtNeg;
            divZeroReg <= (bus.rt_data == {XLEN{1'b0}});
            operandReg <= rtMag;
            accReg     <= {{XLEN{1'b0}}, rsMag};
            remReg     <= {XLEN{1'b0}};
            cnt        <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1'b1);
          if (isDiv) begin
            remReg               <= divDiff[XLEN] ? divShift[XLEN-1:0] : divDiff[XLEN-1:0];
            accReg[XLEN-1:0]     <= {accReg[XLEN-2:0], ~divDiff[XLEN]};
          end else begin
            accReg <= {mulSum, accReg[XLEN-1:1]};
          end
        end
        FIX: begin
          hiReg   <= hiFix;
          loReg   <= loFix;
          doneReg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_out = hiReg;
  assign bus.lo_out = loReg;
  assign bus.busy   = busyReg;
  assign bus.done   = doneReg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: scoreboard of expected HI/LO
// pairs pushed at launch and popped when done pulses.
module tb_hilo_muldiv_unit;
  import mips_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   passes;
  logic [31:0] curHi;
  logic [31:0] curLo;
  exp_t sbQ[$];

  hilo_muldiv_unit_if bus();

  hilo_muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference built on the simulator's own integer arithmetic.
  function automatic exp_t ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    longint x;
    longint y;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] m;
    case (o)
      MD_OP_MULT: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        p = x * y;
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      MD_OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      MD_OP_DIV: begin
        if (b == 32'd0) begin
          r.hi = a;
          r.lo = 32'hFFFFFFFF;
        end else begin
          x = longint'($signed(a));
          y = longint'($signed(b));
          q = x / y;
          m = x % y;
          r.hi = m[31:0];
          r.lo = q[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          r.hi = a;
          r.lo = 32'hFFFFFFFF;
        end else begin
          r.hi = a % b;
          r.lo = a / b;
        end
      end
    endcase
    return r;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic mt);
    exp_t e;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = o;
    bus.rs_data = a;
    bus.rt_data = b;
    bus.hi_we   = mt;
    bus.lo_we   = 1'b0;
    if (mt) curHi = a;
    e.hi = eh;
    e.lo = el;
    sbQ.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  task automatic wait_result(input string name, input int injectAt);
    int   busyCnt;
    int   lat;
    exp_t e;
    busyCnt = 0;
    lat     = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) busyCnt++;
      if (i == 2 || i == 20) begin
        checks++;
        if (bus.hi_out !== curHi || bus.lo_out !== curLo)
          $display("FAIL %s hold@%0d: hi=%h lo=%h, want hi=%h lo=%h", name, i, bus.hi_out, bus.lo_out, curHi, curLo);
        else passes++;
      end
      if (i == injectAt) begin
        bus.start   = 1'b1;
        bus.op      = MD_OP_DIVU;
        bus.rs_data = 32'h0000DEAD;
        bus.rt_data = 32'h00000003;
        bus.hi_we   = 1'b1;
        bus.lo_we   = 1'b1;
      end else begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    checks++;
    if (lat !== 33) $display("FAIL %s latency: got %0d edges, want 33", name, lat);
    else passes++;
    checks++;
    if (busyCnt !== 33) $display("FAIL %s busy cycles: got %0d, want 33", name, busyCnt);
    else passes++;
    if (sbQ.size() == 0) begin
      checks++;
      $display("FAIL %s scoreboard empty: got 0 entries, want 1", name);
    end else begin
      e = sbQ.pop_front();
      checks++;
      if (bus.hi_out !== e.hi) $display("FAIL %s HI: got %h, want %h", name, bus.hi_out, e.hi);
      else passes++;
      checks++;
      if (bus.lo_out !== e.lo) $display("FAIL %s LO: got %h, want %h", name, bus.lo_out, e.lo);
      else passes++;
      curHi = e.hi;
      curLo = e.lo;
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL %s after done: done=%b busy=%b, want 0 0", name, bus.done, bus.busy);
    else passes++;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0)
      $display("FAIL reset state: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", bus.busy, bus.done, bus.hi_out, bus.lo_out);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    curHi = 32'd0;
    curLo = 32'd0;
  endtask

  task automatic test_mt();
    @(negedge clk);
    bus.hi_we = 1'b1; bus.rs_data = 32'd1234;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.rs_data = 32'd5678;
    checks++;
    if (bus.hi_out !== 32'd1234) $display("FAIL mthi: got %h, want %h", bus.hi_out, 32'd1234);
    else passes++;
    @(negedge clk);
    bus.lo_we = 1'b0;
    checks++;
    if (bus.lo_out !== 32'd5678 || bus.hi_out !== 32'd1234)
      $display("FAIL mtlo: hi=%h lo=%h, want %h %h", bus.hi_out, bus.lo_out, 32'd1234, 32'd5678);
    else passes++;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.rs_data = 32'hCAFEF00D;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checks++;
    if (bus.hi_out !== 32'hCAFEF00D || bus.lo_out !== 32'hCAFEF00D)
      $display("FAIL mt both: hi=%h lo=%h, want CAFEF00D CAFEF00D", bus.hi_out, bus.lo_out);
    else passes++;
    curHi = 32'hCAFEF00D;
    curLo = 32'hCAFEF00D;
  endtask

  task automatic test_directed();
    launch(MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    wait_result("multu_max", -1);
    launch(MD_OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    wait_result("mult_neg", -1);
    launch(MD_OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    wait_result("mult_minmin", -1);
    launch(MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_result("div_neg", -1);
    launch(MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    wait_result("div_ovf", -1);
    launch(MD_OP_DIV, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 1'b0);
    wait_result("div_zero", -1);
    launch(MD_OP_DIVU, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0);
    wait_result("divu_zero", -1);
    launch(MD_OP_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0);
    wait_result("divu_100_7", -1);
  endtask

  task automatic test_busy_ignore();
    launch(MD_OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    wait_result("busy_ignore", 5);
  endtask

  task automatic test_start_with_mt();
    launch(MD_OP_DIVU, 32'h0000ABCD, 32'h00000010, 32'h0000000D, 32'h00000ABC, 1'b1);
    wait_result("start_mt", -1);
  endtask

  task automatic test_reset_mid_op();
    logic seenDone;
    seenDone = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_OP_MULTU; bus.rs_data = 32'hFFFFFFFF; bus.rt_data = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL midreset pre busy: got %b, want 1", bus.busy);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0 || bus.done !== 1'b0)
      $display("FAIL midreset clear: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", bus.busy, bus.done, bus.hi_out, bus.lo_out);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    curHi = 32'd0;
    curLo = 32'd0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seenDone = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seenDone !== 1'b0 || bus.busy !== 1'b0 || bus.hi_out !== 32'd0)
      $display("FAIL midreset aftermath: done_seen=%b busy=%b hi=%h, want 0 0 0", seenDone, bus.busy, bus.hi_out);
    else passes++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    for (int k = 0; k < 6; k++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom();
      b = (k == 3) ? 32'd0 : $urandom();
      if (k == 1) b = b >> 20;
      e = ref_model(o, a, b);
      launch(o, a, b, e.hi, e.lo, 1'b0);
      wait_result("random", -1);
    end
  endtask

  initial begin
    checks        = 0;
    passes        = 0;
    curHi         = 32'd0;
    curLo         = 32'd0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.rs_data   = 32'd0;
    bus.rt_data   = 32'd0;
    bus.hi_we     = 1'b0;
    bus.lo_we     = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_mt();
    test_directed();
    test_busy_ignore();
    test_start_with_mt();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
